// File: rtl/player_action_ctrl.sv
// Per-player action sequencer that gates walk/jump commands into player_move and
// sequences attack, hit-stun and KO. All state advances on SCEN (frame-enable) ticks.
module player_action_ctrl #(
    parameter int ATK_STARTUP    = 4,
    parameter int ATK_ACTIVE     = 3,
    parameter int ATK_RECOVERY   = 8,
    parameter int HITSTUN_FRAMES = 20,
    parameter int CNT_WIDTH      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       hit_taken,
    input  logic       hp_zero,
    input  logic       jump_active,
    output logic       move_enable,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       attack_hitbox,
    output logic [2:0] state,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WALK    = 3'd1,
        AIR     = 3'd2,
        ATK_SU  = 3'd3,
        ATK_ACT = 3'd4,
        ATK_REC = 3'd5,
        HITSTUN = 3'd6,
        KO      = 3'd7
    } state_e;

    localparam logic [CNT_WIDTH-1:0] SU_LOAD  = CNT_WIDTH'(ATK_STARTUP - 1);
    localparam logic [CNT_WIDTH-1:0] ACT_LOAD = CNT_WIDTH'(ATK_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] REC_LOAD = CNT_WIDTH'(ATK_RECOVERY - 1);
    localparam logic [CNT_WIDTH-1:0] HS_LOAD  = CNT_WIDTH'(HITSTUN_FRAMES - 1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  prev_atk_q, prev_atk_d;
    logic                  prev_jump_q, prev_jump_d;
    logic                  hit_q, hit_d;
    logic                  air_seen_q, air_seen_d;
    logic                  jump_fire;
    logic                  move_enable_q, move_enable_d;
    logic                  move_left_q, move_left_d;
    logic                  move_right_q, move_right_d;
    logic                  jump_q, jump_d;
    logic                  hitbox_q, hitbox_d;
    logic                  busy_q, busy_d;
    logic                  hit_pend, atk_edge, jump_edge;

    assign hit_pend  = hit_q | hit_taken;
    assign atk_edge  = btn_attack & ~prev_atk_q;
    assign jump_edge = btn_jump & ~prev_jump_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            prev_atk_q    <= 1'b0;
            prev_jump_q   <= 1'b0;
            hit_q         <= 1'b0;
            air_seen_q    <= 1'b0;
            move_enable_q <= 1'b1;
            move_left_q   <= 1'b0;
            move_right_q  <= 1'b0;
            jump_q        <= 1'b0;
            hitbox_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            hit_q <= hit_d;
            if (SCEN) begin
                state_q       <= state_d;
                cnt_q         <= cnt_d;
                prev_atk_q    <= prev_atk_d;
                prev_jump_q   <= prev_jump_d;
                air_seen_q    <= air_seen_d;
                move_enable_q <= move_enable_d;
                move_left_q   <= move_left_d;
                move_right_q  <= move_right_d;
                jump_q        <= jump_d;
                hitbox_q      <= hitbox_d;
                busy_q        <= busy_d;
            end
        end
    end

    // The hit latch fills on any cycle and is drained by the next frame tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        air_seen_d  = 1'b0;
        jump_fire   = 1'b0;
        prev_atk_d  = btn_attack;
        prev_jump_d = btn_jump;
        hit_d       = SCEN ? 1'b0 : hit_pend;
        if (hp_zero) begin
            state_d = KO;
            cnt_d   = '0;
        end else if (hit_pend && state_q != KO) begin
            state_d = HITSTUN;
            cnt_d   = HS_LOAD;
        end else begin
            case (state_q)
                IDLE, WALK: begin
                    cnt_d = '0;
                    if (atk_edge) begin
                        state_d = ATK_SU;
                        cnt_d   = SU_LOAD;
                    end else if (jump_edge) begin
                        state_d   = AIR;
                        jump_fire = 1'b1;
                    end else if (btn_left ^ btn_right) begin
                        state_d = WALK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ATK_SU: begin
                    if (cnt_q == '0) begin
                        state_d = ATK_ACT;
                        cnt_d   = ACT_LOAD;
                    end else cnt_d = cnt_q - 1'b1;
                end
                ATK_ACT: begin
                    if (cnt_q == '0) begin
                        state_d = ATK_REC;
                        cnt_d   = REC_LOAD;
                    end else cnt_d = cnt_q - 1'b1;
                end
                ATK_REC: begin
                    if (cnt_q == '0) state_d = IDLE;
                    else cnt_d = cnt_q - 1'b1;
                end
                AIR: begin
                    if (air_seen_q && !jump_active) state_d = IDLE;
                    else air_seen_d = air_seen_q | jump_active;
                end
                HITSTUN: begin
                    // Stun may expire mid-air; hold at zero until landing.
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    else if (!jump_active) state_d = IDLE;
                end
                default: state_d = KO;
            endcase
        end
    end

    always_comb begin
        move_enable_d = !(state_d == ATK_SU || state_d == ATK_ACT ||
                          state_d == ATK_REC || state_d == KO);
        move_left_d   = (jump_fire || state_d == WALK) && btn_left && !btn_right;
        move_right_d  = (jump_fire || state_d == WALK) && btn_right && !btn_left;
        jump_d        = jump_fire;
        hitbox_d      = (state_d == ATK_ACT);
        busy_d        = !(state_d == IDLE || state_d == WALK);
    end

    assign move_enable   = move_enable_q;
    assign move_left     = move_left_q;
    assign move_right    = move_right_q;
    assign jump          = jump_q;
    assign attack_hitbox = hitbox_q;
    assign state         = state_q;
    assign busy          = busy_q;

endmodule

// File: doc/player_action_ctrl.md
Name: player_action_ctrl

Overview:
Per-player action sequencer that sits between the debounced button inputs and player_move. It arbitrates walk, jump, attack, hit-stun and KO, and gates the move_enable/move_left/move_right/jump commands into player_move. It also drives the attack hitbox window consumed by the collision/damage logic. All state advances only on SCEN (frame-enable) cycles.

Parameters:
ATK_STARTUP, 4, frames from the attack press until the hitbox turns on
ATK_ACTIVE, 3, frames the hitbox is asserted
ATK_RECOVERY, 8, frames of lockout after the hitbox turns off
HITSTUN_FRAMES, 20, frames of input lockout after a hit is taken
CNT_WIDTH, 6, frame counter width; must hold max(all frame params)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SCEN  in  1  one-cycle frame-enable tick; all state updates are qualified by it
btn_left  in  1  level, held-left request
btn_right  in  1  level, held-right request
btn_jump  in  1  level, jump button
btn_attack  in  1  level, attack button
hit_taken  in  1  pulse from damage logic; latched until the next SCEN
hp_zero  in  1  level, this player's HP is exhausted
jump_active  in  1  from player_move, high while airborne
move_enable  out  1  to player_move
move_left  out  1  to player_move
move_right  out  1  to player_move
jump  out  1  to player_move, one-frame pulse
attack_hitbox  out  1  hitbox valid window
state  out  3  current state code
busy  out  1  high in any state other than IDLE or WALK

Behaviour:
- States and codes: IDLE=0, WALK=1, AIR=2, ATK_SU=3, ATK_ACT=4, ATK_REC=5, HITSTUN=6, KO=7.
- Reset values: state=IDLE, frame counter=0, all outputs 0 except move_enable=1. Edge registers and the hit latch are cleared. Reset mid-operation aborts any attack, stun or jump immediately.
- Edge detection for attack and jump: the prev-button registers sample only on SCEN. A rising edge means btn=1 at this SCEN and 0 at the previous SCEN. Holding a button never repeats the action.
- hit_taken is latched on any clk cycle. It is consumed and cleared at the next SCEN.
- Every SCEN, the first matching row applies (highest priority first):
  1. hp_zero: go to KO from any state. KO is terminal until reset.
  2. hit latch set and state is not KO: go to HITSTUN and load the counter with HITSTUN_FRAMES-1. A hit during HITSTUN reloads the counter.
  3. In IDLE or WALK:
     - attack edge: go to ATK_SU with counter=ATK_STARTUP-1.
     - else jump edge: go to AIR and pulse jump=1 for exactly this frame. move_left/move_right carry the held direction for this frame only.
     - else exactly one of left/right held: go to WALK with the matching command.
     - else (none or both held): go to IDLE with commands 0.
  4. Attack phases: when the counter reaches 0, advance ATK_SU -> ATK_ACT (load ATK_ACTIVE-1) -> ATK_REC (load ATK_RECOVERY-1) -> IDLE; otherwise decrement the counter. Buttons are ignored; presses during ATK are not buffered.
  5. AIR: commands 0, jump 0. A sticky air_seen flag sets when jump_active=1. Return to IDLE on the first SCEN with air_seen=1 and jump_active=0. attack and jump edges are ignored in AIR.
  6. HITSTUN: decrement the counter. Exit to IDLE when counter=0 and jump_active=0; otherwise hold at 0.
- move_enable is 0 in ATK_SU, ATK_ACT, ATK_REC and KO, and 1 otherwise. It stays 1 in HITSTUN, so a hit in mid-air lets the jump arc finish with no commands.
- attack_hitbox is 1 only in ATK_ACT.
- All outputs are registered and change only on SCEN cycles. Latency: a button sampled at SCEN N yields a command visible after that edge, which player_move consumes at SCEN N+1.
- Counter arithmetic is unsigned, CNT_WIDTH bits, and never wraps: it saturates at 0.
- Simultaneous events: an attack edge and a jump edge together give the attack.

Test Plan:
- Reset, then hold btn_right for 5 SCEN -> state=1 and move_right=1 from SCEN 1; move_left=0; move_enable=1 throughout. Hold both buttons -> state=0, no commands.
- Press btn_attack once (held 30 frames) -> ATK_SU for 4 frames, then attack_hitbox=1 for exactly 3 frames, then ATK_REC for 8 frames, then IDLE; move_enable=0 for all 15 frames; no second attack.
- btn_jump edge with btn_left held -> jump=1 and move_left=1 for one frame, state=2. Model jump_active high for 40 frames -> IDLE on the first SCEN after it falls; a jump press during AIR is ignored.
- hit_taken pulse between SCENs during ATK_ACT -> next SCEN gives HITSTUN, attack_hitbox=0, move_enable=1. A second hit at frame 10 restarts the count, so 20 frames total after the second hit -> IDLE.
- hit_taken during AIR -> HITSTUN. The counter expires while jump_active=1; the state holds until jump_active falls, then goes to IDLE.
- hp_zero asserted during WALK -> KO, all commands 0, move_enable=0. Buttons and hits are ignored; an async reset mid-frame returns to IDLE.
